dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data memory between two requesters: the CPU load/store path
//  (MemRead/MemWrite with ALUResult address) and an external loader/debug port.
//  Sequences each access over MEM_LAT cycles and stalls the CPU by driving cpu_stall.
//  Top level ties PCWrite = ~cpu_stall.
//  Sits between the Execute/WriteBack stages and MEM, replacing their direct connection.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  MEM_LAT     1   cycles per memory access; legal range 1..15
//  STARVE_MAX  4   consecutive CPU wins tolerated before the ext port is forced through; legal range 1..15
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU access pending (MemRead|MemWrite)
//  cpu_we     in   1       1 = store, 0 = load
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU store data
//  cpu_rdata  out  DATA_W  CPU load data
//  cpu_stall  out  1       hold PC; CPU access not yet complete
//  ext_req    in   1       external access request, level
//  ext_we     in   1       1 = write, 0 = read
//  ext_addr   in   ADDR_W  external address
//  ext_wdata  in   DATA_W  external write data
//  ext_gnt    out  1       external access in progress
//  ext_done   out  1       1-cycle completion pulse
//  ext_rdata  out  DATA_W  external read data, registered
//  mem_addr   out  ADDR_W  to MEM addr_in
//  mem_wdata  out  DATA_W  to MEM wr_data
//  mem_read   out  1       to MEM MemRead
//  mem_write  out  1       to MEM MemWrite
//  mem_rdata  in   DATA_W  from MEM rd_data
// BEHAVIOUR
//  Reset (reset=0):
//   - state=IDLE; cnt=0; starve=0
//   - ext_done=0; ext_rdata=0
//   - mem_* = 0; cpu_rdata = 0; ext_gnt = 0
//   - cpu_stall forced 0 while reset is low
//  FSM states: IDLE, CPU_BUSY, EXT_BUSY.
//  - IDLE:
//    - mem_read = mem_write = 0; mem_addr = mem_wdata = 0
//    - Arbitration: cpu_req only -> CPU_BUSY; ext_req only -> EXT_BUSY
//    - Both requesting: CPU wins unless starve==STARVE_MAX, in which case ext wins
//  - BUSY states:
//    - mem_* driven from the granted port for exactly MEM_LAT cycles
//    - cnt runs 0..MEM_LAT-1; at cnt==MEM_LAT-1 -> IDLE
//  - Granted-port inputs are sampled combinationally and must stay stable until completion.
//  CPU path:
//   - cpu_stall = cpu_req & ~(state==CPU_BUSY & cnt==MEM_LAT-1)
//   - A CPU memory instruction therefore costs MEM_LAT+1 cycles, with MEM_LAT stall cycles.
//   - cpu_rdata = mem_rdata while state==CPU_BUSY, else 0
//     (the register file writes at the final edge).
//  Ext path:
//   - ext_gnt = (state==EXT_BUSY)
//   - At the final-cycle edge: ext_rdata <= mem_rdata for reads (unchanged for writes).
//   - ext_done pulses for one cycle, in the cycle after the final access cycle.
//   - Dropping ext_req before the grant cancels the request.
//   - Once granted, the access always completes.
//   - ext_req still high after ext_done is treated as a new request.
//  Starvation counter:
//   - starve+1 on each IDLE arbitration where both request and CPU wins
//   - starve=0 on ext grant, or whenever ext_req=0
//   - saturates at STARVE_MAX
//  Reset mid-access:
//   - outputs clear immediately (mem_write drops asynchronously)
//   - no ext_done; the interrupted access is abandoned
//  Never drive mem_read and mem_write high simultaneously;
//  mem_read = ~we and mem_write = we of the granted port.
// TESTING
//  1. reset=0 with cpu_req=ext_req=1 -> all outputs 0, cpu_stall=0. Release reset -> CPU granted on the next edge.
//  2. MEM_LAT=1, CPU load 0x10, mem_rdata=0xDEADBEEF:
//     - cycle0: stall=1
//     - cycle1: mem_read=1, mem_addr=0x10, cpu_rdata=0xDEADBEEF, stall=0
//  3. MEM_LAT=3, ext write 0x40/0x12345678:
//     - ext_gnt and mem_write high for 3 cycles (1..3)
//     - ext_done=1 in cycle 4 only
//  4. STARVE_MAX=2, both requesting continuously -> grant order CPU, CPU, EXT, CPU, CPU, EXT.
//  5. MEM_LAT=3, reset asserted in 2nd cycle of an ext write -> mem_write=0 at once, no ext_done, IDLE after release.
//  6. ext_req pulsed 1 cycle while CPU busy (dropped before grant) -> no EXT_BUSY, ext_done never asserts.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory between the CPU load/store path and an external
// loader/debug port. Each access occupies the memory for MEM_LAT cycles. The
// CPU is held with cpu_stall until its access is in its final cycle. The
// external port is a level request answered by ext_gnt and a one-cycle
// ext_done pulse. A starvation counter forces the external port through after
// STARVE_MAX consecutive CPU wins while both ports were requesting.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU access request (level while pending)
//   cpu_rdata, cpu_stall   CPU load data (valid during CPU access), PC hold
//   ext_req/we/addr/wdata  external access request (level)
//   ext_gnt, ext_done      access in progress, completion pulse
//   ext_rdata              external read data, registered at completion
//   mem_addr/wdata/read/write  to the memory
//   mem_rdata              from the memory
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,   // 1..15
    parameter int STARVE_MAX = 4    // 1..15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        EXT_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        starve_q, starve_d;
    logic              ext_done_q, ext_done_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic last_cycle;
    logic ext_win;
    logic ext_grant;
    logic ext_finish;

    assign last_cycle = (cnt_q == LAST_CNT);
    // External port wins a contested arbitration only once it has lost
    // STARVE_MAX times in a row.
    assign ext_win    = ext_req & (~cpu_req | (starve_q == STARVE_LIM));
    assign ext_grant  = (state_q == IDLE) & ext_win;
    assign ext_finish = (state_q == EXT_BUSY) & last_cycle;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: every flop resets asynchronously so an access interrupted by
    // reset is abandoned at once; sequential state uses non-blocking
    // assignments only, so all flops see the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            starve_q    <= 4'd0;
            ext_done_q  <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            ext_done_q  <= ext_done_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (ext_win)      state_d = EXT_BUSY;
                else if (cpu_req) state_d = CPU_BUSY;
            end
            CPU_BUSY, EXT_BUSY: begin
                if (last_cycle) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Starvation counter: counts contested CPU wins, clears on any ext grant
    // or whenever the external port stops asking.
    always_comb begin
        starve_d = starve_q;
        if (!ext_req || ext_grant) begin
            starve_d = 4'd0;
        end else if ((state_q == IDLE) && cpu_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // External completion: pulse in the cycle after the final access cycle,
    // capture read data on the final edge, hold it across writes.
    always_comb begin
        ext_done_d  = ext_finish;
        ext_rdata_d = ext_rdata_q;
        if (ext_finish && !ext_we) begin
            ext_rdata_d = mem_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cpu_rdata = '0;
        ext_gnt   = 1'b0;
        unique case (state_q)
            CPU_BUSY: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_read  = ~cpu_we;
                mem_write = cpu_we;
                cpu_rdata = mem_rdata;
            end
            EXT_BUSY: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_read  = ~ext_we;
                mem_write = ext_we;
                ext_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    // The CPU is released in the final cycle of its own access so the
    // register file can write at that edge; reset forces the stall low.
    assign cpu_stall = reset & cpu_req & ~((state_q == CPU_BUSY) & last_cycle);
    assign ext_done  = ext_done_q;
    assign ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiter instances share one set of stimulus:
//   dut_a: MEM_LAT=1, STARVE_MAX=2  (single-cycle access, fairness order)
//   dut_b: MEM_LAT=3, STARVE_MAX=4  (multi-cycle access, reset mid-access)
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;

    logic [31:0] a_cpu_rdata, a_ext_rdata, a_mem_addr, a_mem_wdata;
    logic        a_cpu_stall, a_ext_gnt, a_ext_done, a_mem_read, a_mem_write;
    logic [31:0] b_cpu_rdata, b_ext_rdata, b_mem_addr, b_mem_wdata;
    logic        b_cpu_stall, b_ext_gnt, b_ext_done, b_mem_read, b_mem_write;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(2)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(a_ext_gnt), .ext_done(a_ext_done), .ext_rdata(a_ext_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(b_ext_gnt), .ext_done(b_ext_done), .ext_rdata(b_ext_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves reset asserted and both requests idle, at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        cpu_req = 1'b0;
        ext_req = 1'b0;
        cpu_we  = 1'b0;
        ext_we  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] gseq;
    int          ng;
    logic        prev_e;
    logic [3:0]  stv;
    logic        any_done, any_gnt;

    initial begin
        // ---- Reset with both ports requesting --------------------------
        reset     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0010;
        cpu_wdata = 32'h0;
        ext_req   = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = 32'h0000_0080;
        ext_wdata = 32'h0;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("rst_cpu_stall",   a_cpu_stall, 0);
        chk("rst_cpu_stall_b", b_cpu_stall, 0);
        chk("rst_mem_read",    a_mem_read,  0);
        chk("rst_mem_write",   a_mem_write, 0);
        chk("rst_mem_addr",    a_mem_addr,  0);
        chk("rst_cpu_rdata",   a_cpu_rdata, 0);
        chk("rst_ext_gnt",     a_ext_gnt,   0);
        chk("rst_ext_done",    a_ext_done,  0);
        chk("rst_ext_rdata",   a_ext_rdata, 0);

        // ---- CPU load, MEM_LAT=1 ----------------------------------------
        reset = 1'b1;
        #1;
        chk("ld_c0_stall", a_cpu_stall, 1);
        @(negedge clk);
        chk("ld_c1_mem_read",  a_mem_read,  1);
        chk("ld_c1_mem_write", a_mem_write, 0);
        chk("ld_c1_mem_addr",  a_mem_addr,  32'h0000_0010);
        chk("ld_c1_cpu_rdata", a_cpu_rdata, 32'hDEAD_BEEF);
        chk("ld_c1_stall",     a_cpu_stall, 0);
        chk("ld_c1_ext_gnt",   a_ext_gnt,   0);
        chk("ld_c1_b_read",    b_mem_read,  1);
        chk("ld_c1_b_stall",   b_cpu_stall, 1);

        // ---- Starvation order, both requesting (first CPU already seen) -
        gseq   = 32'h0;
        ng     = 0;
        prev_e = 1'b0;
        for (int i = 0; i < 20 && ng < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (prev_e) chk("fair_ext_done", a_ext_done, 1);
            prev_e = a_ext_gnt;
            if (a_ext_gnt) begin
                gseq = {gseq[30:0], 1'b1};
                ng++;
                chk("fair_ext_addr", a_mem_addr, 32'h0000_0080);
            end else if (a_mem_read || a_mem_write) begin
                gseq = {gseq[30:0], 1'b0};
                ng++;
            end
        end
        chk("fair_grant_count", ng, 5);
        chk("fair_grant_order", gseq, 32'b01001);   // C E C C E
        chk("fair_ext_rdata",   a_ext_rdata, 32'hDEAD_BEEF);

        // ---- External write, MEM_LAT=3 ----------------------------------
        do_reset();
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 32'h0000_0040;
        ext_wdata = 32'h1234_5678;
        reset     = 1'b1;
        #1;
        chk("extw_c0_gnt", b_ext_gnt, 0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) ext_req = 1'b0;
            @(negedge clk);
            chk("extw_gnt",       b_ext_gnt,   1);
            chk("extw_mem_write", b_mem_write, 1);
            chk("extw_mem_read",  b_mem_read,  0);
            chk("extw_mem_addr",  b_mem_addr,  32'h0000_0040);
            chk("extw_mem_wdata", b_mem_wdata, 32'h1234_5678);
            chk("extw_done_early", b_ext_done, 0);
        end
        @(negedge clk);
        chk("extw_c4_done",      b_ext_done,  1);
        chk("extw_c4_gnt",       b_ext_gnt,   0);
        chk("extw_c4_mem_write", b_mem_write, 0);
        chk("extw_c4_rdata",     b_ext_rdata, 0);
        @(negedge clk);
        chk("extw_c5_done", b_ext_done, 0);

        // ---- CPU store, MEM_LAT=3: stall pattern 1,1,1,0 ----------------
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0044;
        cpu_wdata = 32'h0000_A5A5;
        #1;
        stv = {3'b000, b_cpu_stall};
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            stv = {stv[2:0], b_cpu_stall};
            if (c == 1) begin
                chk("st_mem_write", b_mem_write, 1);
                chk("st_mem_wdata", b_mem_wdata, 32'h0000_A5A5);
            end
        end
        chk("st_stall_pattern", {28'h0, stv}, 32'b1110);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;

        // ---- Reset during 2nd cycle of external write -------------------
        do_reset();
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 32'h0000_0040;
        ext_wdata = 32'hCAFE_F00D;
        reset     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rmid_pre_write", b_mem_write, 1);
        reset = 1'b0;
        #1;
        chk("rmid_mem_write", b_mem_write, 0);
        chk("rmid_ext_gnt",   b_ext_gnt,   0);
        chk("rmid_mem_addr",  b_mem_addr,  0);
        ext_req = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        any_done = 1'b0;
        any_gnt  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_done = any_done | b_ext_done;
            any_gnt  = any_gnt | b_ext_gnt | b_mem_write | b_mem_read;
        end
        chk("rmid_no_done", any_done, 0);
        chk("rmid_idle",    any_gnt,  0);

        // ---- ext_req pulse while CPU busy is dropped --------------------
        do_reset();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        reset    = 1'b1;
        any_done = 1'b0;
        any_gnt  = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) ext_req = 1'b1;
            if (c == 2) ext_req = 1'b0;
            if (c == 4) cpu_req = 1'b0;
            @(negedge clk);
            any_gnt  = any_gnt | b_ext_gnt;
            any_done = any_done | b_ext_done;
        end
        chk("pulse_no_gnt",  any_gnt,  0);
        chk("pulse_no_done", any_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
